// File: rtl/chunked_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chunked_serial_adder_pkg
//  Description : Shared state encoding and sizing helper for the chunked
//                serial adder/subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package chunked_serial_adder_pkg;

    // Controller states; two bits cover IDLE/RUN/DONE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices processed per operation
    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage : chunked_serial_adder_pkg
`default_nettype wire

// File: rtl/chunk_ripple_add.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_ripple_add
//  Description : Combinational CHUNK-bit ripple-carry adder slice. Reused
//                every cycle by the serial adder for one operand slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module chunk_ripple_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic w_c;

    // Ripple the carry through each full-adder bit, LSB first
    always_comb begin
        s   = '0;
        w_c = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = a[i] ^ b[i] ^ w_c;
            w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        co = w_c;
    end

endmodule : chunk_ripple_add
`default_nettype wire

// File: rtl/chunked_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : chunked_serial_adder
//  Description : Multi-cycle two's-complement adder/subtractor. Adds one
//                CHUNK-bit slice per clock (LSB first) through a registered
//                carry, with valid/ready handshakes and cout/ovf/zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module chunked_serial_adder
    import chunked_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_nchunk = nchunk(WIDTH, CHUNK);
    localparam int c_idxw   = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
    localparam logic [c_idxw-1:0] c_last_idx = c_idxw'(c_nchunk - 1);

    // Reject parameter sets the slice datapath cannot cover exactly
    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH)) begin : g_bad_chunk
            $error("chunked_serial_adder: CHUNK must satisfy 1 <= CHUNK <= WIDTH");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t              r_state;
    logic [c_idxw-1:0]   r_idx;
    logic                r_carry;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;      // already inverted for subtraction
    logic [WIDTH-1:0]    r_sum;
    logic                r_cout;
    logic                r_ovf;
    logic                r_zero;
    logic                r_out_valid;
    logic                r_in_ready;

    int                  w_lo;
    logic [CHUNK-1:0]    w_sa;
    logic [CHUNK-1:0]    w_sb;
    logic [CHUNK-1:0]    w_s;
    logic                w_co;
    logic [WIDTH-1:0]    w_sum_next;

    // Select the operand slice addressed by the current index
    always_comb begin
        w_lo = int'(r_idx) * CHUNK;
        w_sa = r_a[w_lo +: CHUNK];
        w_sb = r_b[w_lo +: CHUNK];
    end

    chunk_ripple_add #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a  (w_sa),
        .b  (w_sb),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // Merge the freshly computed slice into the running result
    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[w_lo +: CHUNK] = w_s;
    end

    // Controller, slice index, carry, operand/result and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= sub ? ~b : b;
                        r_carry    <= sub ? 1'b1 : cin;
                        r_sum      <= '0;
                        r_idx      <= '0;
                        r_cout     <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_zero     <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_co;
                    if (r_idx == c_last_idx) begin
                        // Last slice: capture flags from the completed result
                        r_cout      <= w_co;
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
                        r_zero      <= ~|w_sum_next;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule : chunked_serial_adder
`default_nettype wire
